// File: rtl/ddr5_cmd_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ddr5_cmd_scheduler
// Brief    : In-order DDR5 command front-end. A request FIFO feeds a 4-state
//            issue FSM driving addr/wr_data/rd_en/wr_en. Returning read data
//            lands in a credit-protected response FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ddr5_cmd_scheduler #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64,
    parameter int REQ_DEPTH  = 4,
    parameter int RESP_DEPTH = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  busy
);

    localparam int REQ_AW  = $clog2(REQ_DEPTH);
    localparam int REQ_CW  = REQ_AW + 1;
    localparam int RESP_AW = $clog2(RESP_DEPTH);
    localparam int RESP_CW = RESP_AW + 1;
    localparam int CRED_W  = $clog2(RESP_DEPTH + RD_LATENCY + 2) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR1  = 2'd1,
        WR2  = 2'd2,
        RD   = 2'd3
    } state_t;

    // Storage arrays (no reset needed: guarded by counts)
    logic                  req_wr_ram   [REQ_DEPTH];
    logic [ADDR_WIDTH-1:0] req_addr_ram [REQ_DEPTH];
    logic [DATA_WIDTH-1:0] req_data_ram [REQ_DEPTH];
    logic [DATA_WIDTH-1:0] resp_ram     [RESP_DEPTH];

    state_t                state_q,       state_d;
    logic [REQ_AW-1:0]     req_wptr_q,    req_wptr_d;
    logic [REQ_AW-1:0]     req_rptr_q,    req_rptr_d;
    logic [REQ_CW-1:0]     req_count_q,   req_count_d;
    logic [RESP_AW-1:0]    resp_wptr_q,   resp_wptr_d;
    logic [RESP_AW-1:0]    resp_rptr_q,   resp_rptr_d;
    logic [RESP_CW-1:0]    resp_count_q,  resp_count_d;
    logic [RD_LATENCY:0]   inflight_q,    inflight_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,    mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
    logic                  mem_rd_en_q,   mem_rd_en_d;
    logic                  mem_wr_en_q,   mem_wr_en_d;

    logic                  req_push;
    logic                  req_pop;
    logic                  resp_push;
    logic                  resp_pop;
    logic                  issue_rd;
    logic                  credit_ok;
    logic [CRED_W-1:0]     inflight_cnt;

    // Handshakes; ready reflects current occupancy only, so a pop never frees space in the same cycle
    always_comb begin
        req_ready  = !rst && (req_count_q < REQ_CW'(REQ_DEPTH));
        req_push   = req_valid && req_ready;
        resp_valid = (resp_count_q != '0);
        resp_pop   = resp_valid && resp_ready;
        resp_push  = inflight_q[RD_LATENCY];
        resp_data  = resp_valid ? resp_ram[resp_rptr_q] : '0;
    end

    // Read credit: responses held plus reads still travelling must leave room in the response FIFO
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i <= RD_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + CRED_W'(inflight_q[i]);
        end
        credit_ok = (CRED_W'(resp_count_q) + inflight_cnt) < CRED_W'(RESP_DEPTH);
    end

    // Issue FSM: WR1 repeats the write strobe; IDLE/WR2/RD all pick the next command without a bubble
    always_comb begin
        state_d       = state_q;
        req_pop       = 1'b0;
        issue_rd      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        mem_wr_en_d   = 1'b0;
        mem_rd_en_d   = 1'b0;
        case (state_q)
            WR1: begin
                state_d     = WR2;
                mem_wr_en_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                if (req_count_q != '0) begin
                    if (req_wr_ram[req_rptr_q]) begin
                        state_d       = WR1;
                        req_pop       = 1'b1;
                        mem_addr_d    = req_addr_ram[req_rptr_q];
                        mem_wr_data_d = req_data_ram[req_rptr_q];
                        mem_wr_en_d   = 1'b1;
                    end else if (credit_ok) begin
                        state_d     = RD;
                        req_pop     = 1'b1;
                        issue_rd    = 1'b1;
                        mem_addr_d  = req_addr_ram[req_rptr_q];
                        mem_rd_en_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // FIFO pointer/count and in-flight shift register next-state
    always_comb begin
        req_wptr_d    = req_push ? req_wptr_q + REQ_AW'(1) : req_wptr_q;
        req_rptr_d    = req_pop  ? req_rptr_q + REQ_AW'(1) : req_rptr_q;
        req_count_d   = req_count_q + REQ_CW'(req_push) - REQ_CW'(req_pop);
        resp_wptr_d   = resp_push ? resp_wptr_q + RESP_AW'(1) : resp_wptr_q;
        resp_rptr_d   = resp_pop  ? resp_rptr_q + RESP_AW'(1) : resp_rptr_q;
        resp_count_d  = resp_count_q + RESP_CW'(resp_push) - RESP_CW'(resp_pop);
        inflight_d    = '0;
        inflight_d[0] = issue_rd;
        for (int i = 1; i <= RD_LATENCY; i++) begin
            inflight_d[i] = inflight_q[i-1];
        end
    end

    // Control state with asynchronous reset; reset discards queued and in-flight work
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            req_wptr_q    <= '0;
            req_rptr_q    <= '0;
            req_count_q   <= '0;
            resp_wptr_q   <= '0;
            resp_rptr_q   <= '0;
            resp_count_q  <= '0;
            inflight_q    <= '0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            mem_rd_en_q   <= 1'b0;
            mem_wr_en_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_wptr_q    <= req_wptr_d;
            req_rptr_q    <= req_rptr_d;
            req_count_q   <= req_count_d;
            resp_wptr_q   <= resp_wptr_d;
            resp_rptr_q   <= resp_rptr_d;
            resp_count_q  <= resp_count_d;
            inflight_q    <= inflight_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_wr_en_q   <= mem_wr_en_d;
        end
    end

    // FIFO payload storage, written on push only
    always_ff @(posedge clk) begin
        if (req_push) begin
            req_wr_ram[req_wptr_q]   <= req_write;
            req_addr_ram[req_wptr_q] <= req_addr;
            req_data_ram[req_wptr_q] <= req_wdata;
        end
        if (resp_push) begin
            resp_ram[resp_wptr_q] <= mem_rd_data;
        end
    end

    // Registered memory-side outputs and activity indicator
    always_comb begin
        mem_addr    = mem_addr_q;
        mem_wr_data = mem_wr_data_q;
        mem_rd_en   = mem_rd_en_q;
        mem_wr_en   = mem_wr_en_q;
        busy        = (req_count_q != '0) || (state_q != IDLE) ||
                      (|inflight_q) || (resp_count_q != '0);
    end

endmodule
`default_nettype wire
